ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage. Consumes the ID/EX pipeline-register outputs (aluop, alusel, operands, destination, write enable) and produces the write-back triple for the EX/MEM register.
- Single-cycle ALU for logic, shift, add/sub, compare, multiply and HI/LO moves.
- Owns the architectural HI/LO registers.
- Runs a 32-iteration restoring divider FSM and asserts a pipeline stall request while a divide is in flight.

Parameters:
- DIV_CYCLES, 32, number of quotient-bit iterations. Fixed at 32 for 32-bit operands; other values are unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- aluop_i  in  8  operation code, `EXE_*_OP encodings from the shared defines file
- alusel_i  in  3  result class: `EXE_RES_LOGIC / SHIFT / ARITH / MOVE / NOP
- reg1_i  in  32  operand 1 (rs)
- reg2_i  in  32  operand 2 (rt); shift amount in [4:0]
- wd_i  in  5  destination register address
- wreg_i  in  1  destination write enable
- flush_i  in  1  abort the current operation (exception or branch squash)
- wd_o  out  5  destination address to EX/MEM
- wreg_o  out  1  write enable to EX/MEM
- wdata_o  out  32  result to EX/MEM
- stallreq_o  out  1  stall request to the pipeline controller
- hi_o  out  32  current HI register value (debug/observe)
- lo_o  out  32  current LO register value (debug/observe)

Behaviour:
- Reset: HI = LO = 0; divider FSM = IDLE, counter = 0. While rst is high, wd_o = 0, wreg_o = 0, wdata_o = 0, stallreq_o = 0.
- Non-divide ops (combinational from inputs):
  - wd_o = wd_i and wreg_o = wreg_i in the same cycle.
  - wdata_o is selected by alusel_i. NOP class gives 0.
  - LOGIC: AND, OR, XOR, NOR.
  - SHIFT: SLL, SRL, SRA, shifting reg2 by reg1[4:0].
  - ARITH: ADDU, SUBU (mod 2^32); SLT (signed) and SLTU yield 0 or 1.
  - MOVE: MFHI and MFLO return HI or LO. Reads see the value after any write committed on a previous edge.
- MULT/MULTU: 64-bit product of the two operands, signed or unsigned. {HI, LO} <= product on the same clock edge. wreg_o = 0.
- MTHI/MTLO: HI or LO <= reg1 on the same edge. wreg_o = 0.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE, DIV/DIVU presented, reg2 != 0: latch |reg1| into the dividend register and |reg2| into the divisor register. Absolute value applies to DIV only; DIVU takes operands as-is. Latch the sign flags, counter = 0, go to BUSY. stallreq_o = 1 in this cycle.
  - IDLE, DIV/DIVU presented, reg2 == 0: go to DONE with quotient = 0xFFFFFFFF, remainder = reg1. stallreq_o = 1.
  - BUSY: one restoring step per cycle, shift-subtract on a 65-bit partial remainder. Counter increments each cycle; after DIV_CYCLES steps go to DONE. stallreq_o = 1.
  - DONE: apply signs for DIV. Quotient is negated if the operand signs differ; remainder takes the sign of the dividend. LO <= quotient, HI <= remainder on this edge. stallreq_o = 0. Next state is IDLE.
  - Total: divide issued in cycle N holds stallreq for cycles N through N+32. HI/LO update at the end of cycle N+33. Upstream holds the inputs stable while stallreq_o is high.
  - A DIV still presented in the cycle after DONE is the instruction already executed: it does not restart. A one-cycle "done" marker is cleared when aluop_i changes.
- flush_i = 1: FSM goes to IDLE, counter is cleared, no HI/LO write occurs, stallreq_o = 0. Flush overrides every other HI/LO write in that cycle.
- Simultaneous rst and flush: rst wins.

Optional Feature:
- Macro: EX_MADD_EN.
- Defined: MADD, MADDU, MSUB and MSUBU are decoded. {HI, LO} <= {HI, LO} ± 64-bit product, signed or unsigned per op, computed in one cycle. wreg_o = 0.
- Undefined: these aluops decode as NOP. wdata_o = 0 and HI/LO are unchanged.

Test Plan:
- ADDU 0xFFFFFFFF + 0x00000002, wd = 5, wreg = 1 -> same cycle: wdata_o = 0x00000001, wd_o = 5, wreg_o = 1, stallreq_o = 0.
- SRA with reg1 = 4, reg2 = 0x80000000 -> wdata_o = 0xF8000000. SLT with -1 vs 1 -> wdata_o = 1; SLTU with the same operands -> wdata_o = 0.
- MULT -3 × 7, then MFLO and MFHI on the next two cycles -> wdata_o = 0xFFFFFFEB, then 0xFFFFFFFF.
- DIV -7 / 2 issued in cycle N -> stallreq_o high for exactly 33 cycles. Then LO = 0xFFFFFFFD and HI = 0xFFFFFFFF, and MFLO returns 0xFFFFFFFD.
- DIVU 9 / 0 -> 1 stall cycle, then LO = 0xFFFFFFFF and HI = 9. Separately, DIV with flush_i pulsed in BUSY cycle 10 -> stallreq_o drops the same cycle and HI/LO keep their prior values.
- rst asserted mid-divide -> all outputs 0 and HI = LO = 0 next cycle. With EX_MADD_EN and HI:LO = 0:10, MADD 3 × 4 -> HI:LO = 0:22.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
// Single-cycle ALU for logic, shift, add/sub, compare, multiply and HI/LO moves.
// Owns HI/LO and a 32-step restoring divider that requests a pipeline stall
// while a divide is in flight.
// Optional build macro: EX_MADD_EN adds MADD/MADDU/MSUB/MSUBU. Without it those
// opcodes decode as NOP.
//
// Stall handshake: stallreq_o high means "the instruction on aluop_i/reg*_i has
// not finished". Upstream must hold every input stable while stallreq_o is high.
// The instruction retires in the first cycle stallreq_o is low. flush_i
// abandons the instruction and forces stallreq_o low in the same cycle.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // Operation codes shared with the decode stage.
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
`ifdef EX_MADD_EN
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;
`endif

  // Result classes.
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  // Counter value during the final restoring step.
  localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Divider state (div_state_q is the observable FSM state).
  div_state_e  div_state_q;
  logic [5:0]  div_cnt_q;
  logic [63:0] div_work_q;     // {partial remainder, dividend/quotient bits}
  logic [31:0] div_divisor_q;
  logic        div_signed_q;   // apply DIV sign correction in DONE
  logic        div_neg_quo_q;
  logic        div_neg_rem_q;
  logic        div_done_q;     // set for one cycle after DONE
  logic [7:0]  div_done_op_q;  // opcode that just completed

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Datapath intermediates.
  logic [31:0] logic_res, shift_res, arith_res, move_res, alu_res;
  logic [63:0] mul_s, mul_u;
  logic        is_div_op, div_req, hilo_op, div_stall;
  logic [31:0] div_abs1, div_abs2;
  logic [64:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_step;
  logic [31:0] div_quo_fin, div_rem_fin;

  // Single-cycle ALU results, one per result class.
  always_comb begin
    logic_res = '0;
    shift_res = '0;
    arith_res = '0;
    move_res  = '0;
    case (aluop_i)
      EXE_AND_OP:  logic_res = reg1_i & reg2_i;
      EXE_OR_OP:   logic_res = reg1_i | reg2_i;
      EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
      EXE_SLL_OP:  shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP:  shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP:  shift_res = $signed(reg2_i) >>> reg1_i[4:0];
      EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
      EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      EXE_SLTU_OP: arith_res = {31'd0, reg1_i < reg2_i};
      EXE_MFHI_OP: move_res  = hi_q;
      EXE_MFLO_OP: move_res  = lo_q;
      default: ;
    endcase
  end

  // Result class select; NOP and unknown classes produce zero.
  always_comb begin
    alu_res = '0;
    case (alusel_i)
      EXE_RES_LOGIC: alu_res = logic_res;
      EXE_RES_SHIFT: alu_res = shift_res;
      EXE_RES_ARITH: alu_res = arith_res;
      EXE_RES_MOVE:  alu_res = move_res;
      EXE_RES_NOP:   alu_res = '0;
      default:       alu_res = '0;
    endcase
  end

  // 64-bit products; low 64 bits of the sign-extended product is the signed result.
  always_comb begin
    mul_s = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
    mul_u = {32'd0, reg1_i} * {32'd0, reg2_i};
  end

  // Opcode classification: divides, and ops whose only effect is on HI/LO.
  always_comb begin
    is_div_op = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    hilo_op   = is_div_op ||
                (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP) ||
                (aluop_i == EXE_MTHI_OP) || (aluop_i == EXE_MTLO_OP);
`ifdef EX_MADD_EN
    if ((aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP) ||
        (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP)) begin
      hilo_op = 1'b1;
    end
`endif
    // A divide still on the inputs right after DONE already retired.
    div_req   = is_div_op && !(div_done_q && (aluop_i == div_done_op_q));
    div_stall = !flush_i &&
                ((div_state_q == DIV_BUSY) || ((div_state_q == DIV_IDLE) && div_req));
  end

  // Divider operand preparation and one restoring shift-subtract step.
  always_comb begin
    div_abs1  = ((aluop_i == EXE_DIV_OP) && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    div_abs2  = ((aluop_i == EXE_DIV_OP) && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
    div_shift = {div_work_q, 1'b0};
    div_diff  = div_shift[64:32] - {1'b0, div_divisor_q};
    if (!div_diff[32]) begin
      div_step = {div_diff[31:0], div_shift[31:1], 1'b1};
    end else begin
      div_step = div_shift[63:0];
    end
    div_quo_fin = (div_signed_q && div_neg_quo_q) ? (~div_work_q[31:0] + 32'd1)
                                                  : div_work_q[31:0];
    div_rem_fin = (div_signed_q && div_neg_rem_q) ? (~div_work_q[63:32] + 32'd1)
                                                  : div_work_q[63:32];
  end

  // Divider FSM: IDLE latches operands, BUSY iterates, DONE hands results to HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_state_q   <= DIV_IDLE;
      div_cnt_q     <= '0;
      div_work_q    <= '0;
      div_divisor_q <= '0;
      div_signed_q  <= 1'b0;
      div_neg_quo_q <= 1'b0;
      div_neg_rem_q <= 1'b0;
      div_done_q    <= 1'b0;
      div_done_op_q <= '0;
    end else if (flush_i) begin
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= '0;
      div_done_q  <= 1'b0;
    end else begin
      case (div_state_q)
        DIV_IDLE: begin
          div_done_q <= 1'b0;
          if (div_req) begin
            div_cnt_q <= '0;
            if (reg2_i == 32'd0) begin
              // Divide by zero: fixed quotient, remainder is the raw dividend.
              div_work_q   <= {reg1_i, 32'hFFFF_FFFF};
              div_signed_q <= 1'b0;
              div_state_q  <= DIV_DONE;
            end else begin
              div_work_q    <= {32'd0, div_abs1};
              div_divisor_q <= div_abs2;
              div_signed_q  <= (aluop_i == EXE_DIV_OP);
              div_neg_quo_q <= reg1_i[31] ^ reg2_i[31];
              div_neg_rem_q <= reg1_i[31];
              div_state_q   <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          div_work_q <= div_step;
          div_cnt_q  <= div_cnt_q + 6'd1;
          if (div_cnt_q == DIV_LAST) begin
            div_state_q <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          div_state_q   <= DIV_IDLE;
          div_done_q    <= 1'b1;
          div_done_op_q <= aluop_i;
        end
        default: div_state_q <= DIV_IDLE;
      endcase
    end
  end

  // HI/LO next value: divider result wins in DONE, flush cancels any write.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_state_q == DIV_DONE) begin
      hi_d = div_rem_fin;
      lo_d = div_quo_fin;
    end else begin
      case (aluop_i)
        EXE_MULT_OP:  {hi_d, lo_d} = mul_s;
        EXE_MULTU_OP: {hi_d, lo_d} = mul_u;
        EXE_MTHI_OP:  hi_d = reg1_i;
        EXE_MTLO_OP:  lo_d = reg1_i;
`ifdef EX_MADD_EN
        EXE_MADD_OP:  {hi_d, lo_d} = {hi_q, lo_q} + mul_s;
        EXE_MADDU_OP: {hi_d, lo_d} = {hi_q, lo_q} + mul_u;
        EXE_MSUB_OP:  {hi_d, lo_d} = {hi_q, lo_q} - mul_s;
        EXE_MSUBU_OP: {hi_d, lo_d} = {hi_q, lo_q} - mul_u;
`endif
        default: ;
      endcase
    end
    if (flush_i) begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // HI/LO architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // EX/MEM outputs; reset forces everything quiet.
  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i && !hilo_op;
    wdata_o    = alu_res;
    stallreq_o = div_stall;
    if (rst) begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      stallreq_o = 1'b0;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage.
// Build with +define+EX_MADD_EN to check the multiply-accumulate variant.
module tb_ex_stage;

  localparam logic [7:0] NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] AND_OP   = 8'b0010_0100;
  localparam logic [7:0] OR_OP    = 8'b0010_0101;
  localparam logic [7:0] XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] MADD_OP  = 8'b1010_0110;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i, flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference HI/LO and scoreboard.
  logic [31:0] hi_m, lo_m;
  logic [63:0] exp_q[$];
  logic [37:0] last_out;

  logic [7:0] rnd_ops [17] = '{AND_OP, OR_OP, XOR_OP, NOR_OP, SLL_OP, SRL_OP,
                               SRA_OP, SLT_OP, SLTU_OP, ADDU_OP, SUBU_OP,
                               MFHI_OP, MFLO_OP, MTHI_OP, MTLO_OP, MULT_OP,
                               MULTU_OP};

  ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .flush_i    (flush_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .stallreq_o (stallreq_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] sel_of(input logic [7:0] op);
    case (op)
      AND_OP, OR_OP, XOR_OP, NOR_OP:      return SEL_LOGIC;
      SLL_OP, SRL_OP, SRA_OP:             return SEL_SHIFT;
      ADDU_OP, SUBU_OP, SLT_OP, SLTU_OP:  return SEL_ARITH;
      MFHI_OP, MFLO_OP:                   return SEL_MOVE;
      default:                            return SEL_NOP;
    endcase
  endfunction

  function automatic logic is_hilo(input logic [7:0] op);
    case (op)
      MULT_OP, MULTU_OP, MTHI_OP, MTLO_OP, DIV_OP, DIVU_OP: return 1'b1;
`ifdef EX_MADD_EN
      MADD_OP: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_res(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    logic signed [31:0] sbv;
    sa = a;
    sb = b;
    sbv = b;
    case (op)
      AND_OP:  return a & b;
      OR_OP:   return a | b;
      XOR_OP:  return a ^ b;
      NOR_OP:  return ~(a | b);
      SLL_OP:  return b << a[4:0];
      SRL_OP:  return b >> a[4:0];
      SRA_OP:  return sbv >>> a[4:0];
      ADDU_OP: return a + b;
      SUBU_OP: return a - b;
      SLT_OP:  return (sa < sb) ? 32'd1 : 32'd0;
      SLTU_OP: return (a < b) ? 32'd1 : 32'd0;
      MFHI_OP: return hi_m;
      MFLO_OP: return lo_m;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_hilo(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    sa = a;
    sb = b;
    sp = longint'(sa) * longint'(sb);
    up = {32'd0, a} * {32'd0, b};
    case (op)
      MULT_OP:  {hi_m, lo_m} = sp;
      MULTU_OP: {hi_m, lo_m} = up;
      MTHI_OP:  hi_m = a;
      MTLO_OP:  lo_m = a;
`ifdef EX_MADD_EN
      MADD_OP:  {hi_m, lo_m} = {hi_m, lo_m} + sp;
`endif
      default: ;
    endcase
  endtask

  // Driver for single-cycle ops: push expectation, compare at negedge, retire.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input logic we);
    logic [37:0] got;
    aluop_i  = op;
    alusel_i = sel_of(op);
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = d;
    wreg_i   = we;
    exp_q.push_back({26'd0, we & ~is_hilo(op), d, model_res(op, a, b)});
    @(negedge clk);
    got = {wreg_o, wd_o, wdata_o};
    last_out = got;
    check(tag, {26'd0, got}, exp_q.pop_front());
    check({tag, "_stall"}, {63'd0, stallreq_o}, 64'd0);
    check({tag, "_hilo"}, {hi_o, lo_o}, {hi_m, lo_m});
    step();
    model_hilo(op, a, b);
  endtask

  // Driver for divides: count stall cycles, then compare HI/LO after DONE.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stalls);
    logic [31:0] eq, er;
    int sa, sb, stalls;
    bit done;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else if (op == DIV_OP) begin
      eq = sa / sb;
      er = sa % sb;
    end else begin
      eq = a / b;
      er = a % b;
    end
    exp_q.push_back({er, eq});
    aluop_i  = op;
    alusel_i = SEL_NOP;
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = 5'd0;
    wreg_i   = 1'b0;
    stalls   = 0;
    done     = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (stallreq_o) begin
        stalls++;
        step();
      end else begin
        done = 1'b1;
      end
    end
    check({tag, "_timeout"}, {63'd0, done}, 64'd1);
    check({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    check({tag, "_hold"}, {hi_o, lo_o}, {hi_m, lo_m});
    step();
    @(negedge clk);
    check({tag, "_norestart"}, {63'd0, stallreq_o}, 64'd0);
    check({tag, "_hilo"}, {hi_o, lo_o}, exp_q.pop_front());
    hi_m = er;
    lo_m = eq;
    step();
  endtask

  // Stimulus and final report.
  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  op;
    rst = 1'b1; flush_i = 1'b0;
    aluop_i = ADDU_OP; alusel_i = SEL_ARITH;
    reg1_i = 32'h1234_5678; reg2_i = 32'h1; wd_i = 5'd3; wreg_i = 1'b1;
    hi_m = '0; lo_m = '0;
    step();
    @(negedge clk);
    check("reset_outs", {26'd0, stallreq_o, wreg_o, wd_o, wdata_o}, 64'd0);
    check("reset_hilo", {hi_o, lo_o}, 64'd0);
    step();
    rst = 1'b0;

    // Directed ALU cases.
    run_op("addu_wrap", ADDU_OP, 32'hFFFF_FFFF, 32'h2, 5'd5, 1'b1);
    check("tp_addu", {26'd0, last_out}, {26'd0, 1'b1, 5'd5, 32'h1});
    run_op("sra", SRA_OP, 32'd4, 32'h8000_0000, 5'd7, 1'b1);
    check("tp_sra", {32'd0, last_out[31:0]}, 64'hF800_0000);
    run_op("slt", SLT_OP, 32'hFFFF_FFFF, 32'd1, 5'd8, 1'b1);
    check("tp_slt", {32'd0, last_out[31:0]}, 64'd1);
    run_op("sltu", SLTU_OP, 32'hFFFF_FFFF, 32'd1, 5'd8, 1'b1);
    check("tp_sltu", {32'd0, last_out[31:0]}, 64'd0);
    run_op("mult", MULT_OP, 32'hFFFF_FFFD, 32'd7, 5'd9, 1'b1);
    run_op("mflo", MFLO_OP, 32'd0, 32'd0, 5'd10, 1'b1);
    check("tp_mflo", {32'd0, last_out[31:0]}, 64'hFFFF_FFEB);
    run_op("mfhi", MFHI_OP, 32'd0, 32'd0, 5'd11, 1'b1);
    check("tp_mfhi", {32'd0, last_out[31:0]}, 64'hFFFF_FFFF);

    // Divides.
    run_div("div_neg", DIV_OP, 32'hFFFF_FFF9, 32'd2, 33);
    check("tp_div", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_mflo", MFLO_OP, 32'd0, 32'd0, 5'd12, 1'b1);
    check("tp_div_mflo", {32'd0, last_out[31:0]}, 64'hFFFF_FFFD);
    run_div("divu_zero", DIVU_OP, 32'd9, 32'd0, 1);
    check("tp_divu0", {hi_o, lo_o}, {32'd9, 32'hFFFF_FFFF});

    // Flush in BUSY cycle 10.
    aluop_i = DIV_OP; alusel_i = SEL_NOP; reg1_i = 32'd100; reg2_i = 32'd7;
    wd_i = 5'd0; wreg_i = 1'b0;
    for (int i = 0; i < 9; i++) step();
    @(negedge clk);
    check("flush_pre_stall", {63'd0, stallreq_o}, 64'd1);
    step();
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_stall", {63'd0, stallreq_o}, 64'd0);
    step();
    flush_i = 1'b0;
    aluop_i = NOP_OP;
    @(negedge clk);
    check("flush_idle", {63'd0, stallreq_o}, 64'd0);
    check("flush_hilo", {hi_o, lo_o}, {hi_m, lo_m});
    step();

    // Flush beats an MTHI in the same cycle.
    aluop_i = MTHI_OP; reg1_i = 32'hDEAD_BEEF; flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    run_op("flush_mthi", NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0);

    // Randomised single-cycle ops.
    for (int i = 0; i < 60; i++) begin
      op = rnd_ops[$urandom_range(0, 16)];
      ra = $urandom();
      rb = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom();
      run_op("rnd", op, ra, rb, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    // Randomised divides.
    for (int i = 0; i < 4; i++) begin
      ra = $urandom();
      if (ra == 32'h8000_0000) ra = 32'd1;
      rb = 32'($urandom_range(1, 1000));
      if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
      run_div("rnd_div", (i % 2 == 0) ? DIV_OP : DIVU_OP, ra, rb, 33);
    end

    // Multiply-accumulate (NOP when the feature is compiled out).
    run_op("mthi0", MTHI_OP, 32'd0, 32'd0, 5'd0, 1'b0);
    run_op("mtlo10", MTLO_OP, 32'd10, 32'd0, 5'd0, 1'b0);
    run_op("madd", MADD_OP, 32'd3, 32'd4, 5'd4, 1'b0);
`ifdef EX_MADD_EN
    check("tp_madd", {hi_o, lo_o}, {32'd0, 32'd22});
`else
    check("tp_madd", {hi_o, lo_o}, {32'd0, 32'd10});
`endif

    // Reset in the middle of a divide.
    aluop_i = DIV_OP; alusel_i = SEL_NOP; reg1_i = 32'd1000; reg2_i = 32'd3;
    wd_i = 5'd6; wreg_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", {26'd0, stallreq_o, wreg_o, wd_o, wdata_o}, 64'd0);
    step();
    aluop_i = NOP_OP;
    check("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
    hi_m = '0;
    lo_m = '0;
    rst = 1'b0;
    run_op("post_rst", ADDU_OP, 32'd40, 32'd2, 5'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
